// File: rtl/min_hash_selector_if.sv
// Handshake bundle between the hash stage, the min-hash selector
// and the sketch collector.
interface min_hash_selector_if #(
   parameter int SIZE  = 49,
   parameter int WIDTH = 32,
   parameter int IDX_W = 6
);
   logic [SIZE-1:0][WIDTH-1:0] hashResults;
   logic [SIZE-1:0][WIDTH-1:0] kmers;
   logic                       in_valid;
   logic                       in_ready;
   logic [WIDTH-1:0]           min_hash;
   logic [WIDTH-1:0]           min_kmer;
   logic [IDX_W-1:0]           min_index;
   logic                       out_valid;
   logic                       out_ready;

   modport master (
      output hashResults, kmers, in_valid, out_ready,
      input  in_ready, min_hash, min_kmer, min_index, out_valid
   );

   modport slave (
      input  hashResults, kmers, in_valid, out_ready,
      output in_ready, min_hash, min_kmer, min_index, out_valid
   );
endinterface

// File: rtl/min_hash_selector.sv
// Sequential minimizer: scans a captured hash window LANES entries
// per cycle and holds the lowest-index minimum until accepted.
module min_hash_selector #(
   parameter int SIZE  = 49,
   parameter int WIDTH = 32,
   parameter int LANES = 1,
   parameter int IDX_W = 6
) (
   input logic                clk,
   input logic                rstN,
   min_hash_selector_if.slave bus
);
   localparam int PTR_W = $clog2(SIZE + LANES);
   localparam int SEL_W = (SIZE > 1) ? $clog2(SIZE) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t                     state_q;
   state_t                     state_d;
   logic [SIZE-1:0][WIDTH-1:0] hash_q;
   logic [SIZE-1:0][WIDTH-1:0] kmer_q;
   logic [PTR_W-1:0]           ptr;
   logic [WIDTH-1:0]           run_hash;
   logic [WIDTH-1:0]           run_kmer;
   logic [IDX_W-1:0]           run_idx;
   logic [WIDTH-1:0]           c_hash;
   logic [WIDTH-1:0]           c_kmer;
   logic [IDX_W-1:0]           c_idx;
   logic [PTR_W-1:0]           e;
   logic [WIDTH-1:0]           out_hash;
   logic [WIDTH-1:0]           out_kmer;
   logic [IDX_W-1:0]           out_idx;
   logic                       capture;
   logic                       last;

   assign capture = (state_q == IDLE) && bus.in_valid;
   assign last    = (ptr + PTR_W'(LANES)) >= PTR_W'(SIZE);

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.min_hash  = out_hash;
   assign bus.min_kmer  = out_kmer;
   assign bus.min_index = out_idx;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.in_valid) state_d = SCAN;
         SCAN:    if (last) state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Entry 0 loads unconditionally so an all-ones window still reports index 0.
   always_comb begin
      c_hash = run_hash;
      c_kmer = run_kmer;
      c_idx  = run_idx;
      e      = '0;
      for (int l = 0; l < LANES; l++) begin
         e = ptr + PTR_W'(l);
         if (e < PTR_W'(SIZE)) begin
            if ((e == '0) || (hash_q[e[SEL_W-1:0]] < c_hash)) begin
               c_hash = hash_q[e[SEL_W-1:0]];
               c_kmer = kmer_q[e[SEL_W-1:0]];
               c_idx  = IDX_W'(e);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rstN) begin
         state_q  <= IDLE;
         ptr      <= '0;
         run_hash <= '0;
         run_kmer <= '0;
         run_idx  <= '0;
         out_hash <= '0;
         out_kmer <= '0;
         out_idx  <= '0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            ptr      <= '0;
            run_hash <= '1;
            run_kmer <= '0;
            run_idx  <= '0;
         end else if (state_q == SCAN) begin
            ptr      <= ptr + PTR_W'(LANES);
            run_hash <= c_hash;
            run_kmer <= c_kmer;
            run_idx  <= c_idx;
            if (last) begin
               out_hash <= c_hash;
               out_kmer <= c_kmer;
               out_idx  <= c_idx;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (capture) begin
         hash_q <= bus.hashResults;
         kmer_q <= bus.kmers;
      end
   end
endmodule

// File: tb/tb_min_hash_selector.sv
// Bench for min_hash_selector: LANES=1 and LANES=8 instances checked
// every cycle against a window-level reference model.
module tb_min_hash_selector;
   localparam int SIZE  = 49;
   localparam int WIDTH = 32;
   localparam int IDX_W = 6;

   typedef logic [SIZE-1:0][WIDTH-1:0] vec_t;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   cap_a = 0;
   int   cap_b = 0;

   always #5 clk = ~clk;

   min_hash_selector_if #(.SIZE(SIZE), .WIDTH(WIDTH), .IDX_W(IDX_W)) ia ();
   min_hash_selector_if #(.SIZE(SIZE), .WIDTH(WIDTH), .IDX_W(IDX_W)) ib ();

   min_hash_selector #(.SIZE(SIZE), .WIDTH(WIDTH), .LANES(1), .IDX_W(IDX_W)) dut_a (
      .clk(clk), .rstN(rst_a), .bus(ia)
   );
   min_hash_selector #(.SIZE(SIZE), .WIDTH(WIDTH), .LANES(8), .IDX_W(IDX_W)) dut_b (
      .clk(clk), .rstN(rst_b), .bus(ib)
   );

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", nm, got, want);
      end
   endtask

   // Reference: first index holding the smallest unsigned value.
   task automatic ref_min(input vec_t h, input vec_t k, output logic [31:0] mh,
                          output logic [31:0] mk, output logic [5:0] mi);
      int best = 0;
      for (int i = 1; i < SIZE; i++)
         if (h[i] < h[best]) best = i;
      mh = h[best];
      mk = k[best];
      mi = 6'(best);
   endtask

   // Window-level model: 0 = accepting, 1 = busy for n edges, 2 = holding result.
   bit          m_live[2];
   int          m_phase[2];
   int          m_cnt[2];
   logic [31:0] m_hash[2], m_kmer[2], p_hash[2], p_kmer[2];
   logic [5:0]  m_idx[2], p_idx[2];

   task automatic model_step(input int d, input logic rst, input logic iv, input logic ordy,
                             input vec_t h, input vec_t k, input int n);
      if (rst) begin
         m_live[d] = 1'b1;
         m_phase[d] = 0;
         m_hash[d] = '0;
         m_kmer[d] = '0;
         m_idx[d] = '0;
      end else if (m_live[d]) begin
         case (m_phase[d])
            0: if (iv) begin
               ref_min(h, k, p_hash[d], p_kmer[d], p_idx[d]);
               m_cnt[d] = n;
               m_phase[d] = 1;
            end
            1: begin
               m_cnt[d]--;
               if (m_cnt[d] == 0) begin
                  m_hash[d] = p_hash[d];
                  m_kmer[d] = p_kmer[d];
                  m_idx[d] = p_idx[d];
                  m_phase[d] = 2;
               end
            end
            default: if (ordy) m_phase[d] = 0;
         endcase
      end
   endtask

   task automatic chk(input int d, input string p, input logic ir, input logic ov,
                      input logic [31:0] mh, input logic [31:0] mk, input logic [5:0] mi);
      if (m_live[d]) begin
         check({p, "in_ready"}, 64'(ir), 64'(m_phase[d] == 0));
         check({p, "out_valid"}, 64'(ov), 64'(m_phase[d] == 2));
         check({p, "min_hash"}, 64'(mh), 64'(m_hash[d]));
         check({p, "min_kmer"}, 64'(mk), 64'(m_kmer[d]));
         check({p, "min_index"}, 64'(mi), 64'(m_idx[d]));
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      model_step(0, rst_a, ia.in_valid, ia.out_ready, ia.hashResults, ia.kmers, 49);
      model_step(1, rst_b, ib.in_valid, ib.out_ready, ib.hashResults, ib.kmers, 7);
   end

   always @(negedge clk) begin
      chk(0, "a_", ia.in_ready, ia.out_valid, ia.min_hash, ia.min_kmer, ia.min_index);
      chk(1, "b_", ib.in_ready, ib.out_valid, ib.min_hash, ib.min_kmer, ib.min_index);
   end

   task automatic gen(output vec_t h, output vec_t k, input int mode);
      for (int i = 0; i < SIZE; i++) begin
         case (mode)
            0: h[i] = $urandom;
            1: h[i] = $urandom_range(0, 7);
            default: h[i] = ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFF_FFFF;
         endcase
         k[i] = $urandom;
      end
   endtask

   task automatic cap_a_t(input vec_t h, input vec_t k);
      int n = 0;
      ia.hashResults = h;
      ia.kmers = k;
      ia.in_valid = 1'b1;
      while (!ia.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("a_cap_ready", 64'(ia.in_ready), 64'd1);
      @(negedge clk);
      ia.in_valid = 1'b0;
      cap_a = cyc;
   endtask

   task automatic wait_a(input vec_t h, input vec_t k);
      int n = 0;
      logic [31:0] eh, ek;
      logic [5:0] ei;
      while (!ia.out_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("a_done", 64'(ia.out_valid), 64'd1);
      check("a_latency", 64'(cyc - cap_a), 64'd49);
      ref_min(h, k, eh, ek, ei);
      check("a_res_hash", 64'(ia.min_hash), 64'(eh));
      check("a_res_index", 64'(ia.min_index), 64'(ei));
   endtask

   task automatic ack_a();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ia.out_ready = 1'b1;
      @(negedge clk);
      ia.out_ready = 1'b0;
   endtask

   task automatic cap_b_t(input vec_t h, input vec_t k);
      int n = 0;
      ib.hashResults = h;
      ib.kmers = k;
      ib.in_valid = 1'b1;
      while (!ib.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("b_cap_ready", 64'(ib.in_ready), 64'd1);
      @(negedge clk);
      ib.in_valid = 1'b0;
      cap_b = cyc;
   endtask

   // Junk in_valid/out_ready during the scan must be ignored.
   task automatic wait_b();
      int n = 0;
      while (!ib.out_valid && n < 300) begin
         ib.in_valid = 1'($urandom_range(0, 1));
         ib.out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         n++;
      end
      ib.in_valid = 1'b0;
      ib.out_ready = 1'b0;
      check("b_done", 64'(ib.out_valid), 64'd1);
      check("b_latency", 64'(cyc - cap_b), 64'd7);
   endtask

   task automatic ack_b();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ib.out_ready = 1'b1;
      @(negedge clk);
      ib.out_ready = 1'b0;
   endtask

   task automatic run_a();
      vec_t h, k, h2, k2;
      logic [31:0] eh, ek;
      logic [5:0] ei;
      @(negedge clk);
      @(negedge clk);
      rst_a = 1'b0;
      check("a_rst_in_ready", 64'(ia.in_ready), 64'd1);
      check("a_rst_out_valid", 64'(ia.out_valid), 64'd0);
      check("a_rst_hash", 64'(ia.min_hash), 64'd0);
      for (int i = 0; i < SIZE; i++) begin
         h[i] = 32'(200 - i);
         k[i] = 32'h1000 + 32'(i);
      end
      cap_a_t(h, k);
      wait_a(h, k);
      check("t1_hash", 64'(ia.min_hash), 64'd152);
      check("t1_index", 64'(ia.min_index), 64'd48);
      check("t1_kmer", 64'(ia.min_kmer), 64'h1030);
      ack_a();
      for (int i = 0; i < SIZE; i++) h[i] = 32'd254;
      h[5] = 32'd3;
      h[17] = 32'd3;
      h[40] = 32'd3;
      cap_a_t(h, k);
      wait_a(h, k);
      check("t2_index", 64'(ia.min_index), 64'd5);
      check("t2_hash", 64'(ia.min_hash), 64'd3);
      ack_a();
      h = '0;
      cap_a_t(h, k);
      wait_a(h, k);
      check("t2z_index", 64'(ia.min_index), 64'd0);
      check("t2z_kmer", 64'(ia.min_kmer), 64'h1000);
      ack_a();
      gen(h, k, 0);
      gen(h2, k2, 1);
      cap_a_t(h, k);
      wait_a(h, k);
      ia.hashResults = h2;
      ia.kmers = k2;
      ia.in_valid = 1'b1;
      repeat (20) @(negedge clk);
      ref_min(h, k, eh, ek, ei);
      check("t4_hash", 64'(ia.min_hash), 64'(eh));
      check("t4_kmer", 64'(ia.min_kmer), 64'(ek));
      check("t4_valid", 64'(ia.out_valid), 64'd1);
      check("t4_in_ready", 64'(ia.in_ready), 64'd0);
      ia.out_ready = 1'b1;
      @(negedge clk);
      ia.out_ready = 1'b0;
      check("t4_idle", 64'(ia.in_ready), 64'd1);
      check("t4_hold_kmer", 64'(ia.min_kmer), 64'(ek));
      @(negedge clk);
      check("t4_recap", 64'(ia.in_ready), 64'd0);
      cap_a = cyc;
      ia.in_valid = 1'b0;
      wait_a(h2, k2);
      ack_a();
      gen(h, k, 0);
      cap_a_t(h, k);
      repeat (19) @(negedge clk);
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      check("t5_in_ready", 64'(ia.in_ready), 64'd1);
      check("t5_out_valid", 64'(ia.out_valid), 64'd0);
      check("t5_hash", 64'(ia.min_hash), 64'd0);
      check("t5_index", 64'(ia.min_index), 64'd0);
      gen(h, k, 1);
      cap_a_t(h, k);
      wait_a(h, k);
      ack_a();
      h = '1;
      gen(h2, k, 0);
      cap_a_t(h, k);
      ia.hashResults = '0;
      ia.kmers = h2;
      wait_a(h, k);
      check("t6_hash", 64'(ia.min_hash), 64'hFFFF_FFFF);
      check("t6_index", 64'(ia.min_index), 64'd0);
      check("t6_kmer", 64'(ia.min_kmer), 64'(k[0]));
      ack_a();
      for (int w = 0; w < 20; w++) begin
         gen(h, k, w % 3);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         cap_a_t(h, k);
         wait_a(h, k);
         ack_a();
      end
   endtask

   task automatic run_b();
      vec_t h, k;
      @(negedge clk);
      @(negedge clk);
      rst_b = 1'b0;
      for (int i = 0; i < SIZE; i++) begin
         h[i] = $urandom_range(1, 1000);
         k[i] = $urandom;
      end
      h[48] = 32'd0;
      cap_b_t(h, k);
      wait_b();
      check("t3_index", 64'(ib.min_index), 64'd48);
      check("t3_hash", 64'(ib.min_hash), 64'd0);
      check("t3_kmer", 64'(ib.min_kmer), 64'(k[48]));
      ack_b();
      for (int w = 0; w < 60; w++) begin
         gen(h, k, w % 3);
         if (w % 5 == 4) h[$urandom_range(42, 48)] = 32'd0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         cap_b_t(h, k);
         wait_b();
         ack_b();
      end
   endtask

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      ia.hashResults = '0;
      ia.kmers = '0;
      ia.in_valid = 1'b0;
      ia.out_ready = 1'b0;
      ib.hashResults = '0;
      ib.kmers = '0;
      ib.in_valid = 1'b0;
      ib.out_ready = 1'b0;
      fork
         run_a();
         run_b();
      join
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/min_hash_selector.md
Name: min_hash_selector

Overview:
- Downstream consumer of the per-kmer hash stage.
- Accepts one 49-entry vector of hash results, plus the matching kmer vector, through a valid/ready handshake.
- Scans the entries sequentially, LANES entries per cycle, and returns the minimum hash, its kmer and its index. This is the minimizer / MinHash sketch element for one 128-bit DNA window.
- The result is held on the output until the sketch collector accepts it.

Parameters:
- SIZE, 49: number of kmers / hash entries per window.
- WIDTH, 32: bit width of each kmer and each hash entry.
- LANES, 1: entries compared per scan cycle; legal range 1..SIZE. It need not divide SIZE.
- IDX_W, 6: width of the index output; must satisfy 2**IDX_W >= SIZE.

Ports:
- clk, input, 1: global clock; all state updates on the rising edge.
- rstN, input, 1: synchronous reset, active-high (rstN==1 resets on the rising clk edge).
- hashResults, input, SIZE x WIDTH (packed [SIZE-1:0][WIDTH-1:0]): hash per kmer, from the hash stage.
- kmers, input, SIZE x WIDTH (packed [SIZE-1:0][WIDTH-1:0]): kmer vector aligned with hashResults.
- in_valid, input, 1: the two input vectors are valid.
- in_ready, output, 1: block can capture a new vector.
- min_hash, output, WIDTH: smallest hash in the window.
- min_kmer, output, WIDTH: kmer at the winning index.
- min_index, output, IDX_W: index of the winning entry.
- out_valid, output, 1: result is valid.
- out_ready, input, 1: consumer accepts the result.

Behaviour:
- **States:** IDLE, SCAN, DONE.
- **Reset** (rstN==1 at a clk edge, from any state):
  - state goes to IDLE; scan pointer, running minimum and all outputs are cleared.
  - Output values: min_hash=0, min_kmer=0, min_index=0, out_valid=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-SCAN or in DONE discards the window with no output.
- **Flag decode:** in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded from registered state, with no combinational path from in_valid or out_ready.
- **IDLE:** on an edge with in_valid && in_ready:
  - copy hashResults and kmers into internal registers; later changes on the inputs have no effect;
  - set running min = all-ones, index = 0, pointer = 0;
  - go to SCAN.
- **SCAN:** each edge processes entries pointer..pointer+LANES-1.
  - Entries with index >= SIZE are ignored; this covers the partial last group.
  - An entry replaces the running minimum only if it is strictly less, so ties resolve to the lowest index.
  - The pointer advances by LANES.
  - Scan length N = ceil(SIZE/LANES) edges. On the Nth edge, load the final result into min_hash/min_kmer/min_index and go to DONE.
- **Latency:** capture at edge E0, result valid after edge EN.
  - LANES=1: N=49.
  - LANES=7: N=7.
  - LANES=49: N=1.
- **Comparison:** unsigned, full WIDTH bits.
- **All-ones handling:** if every entry equals 2**WIDTH-1, the result is index 0 with that value. The all-ones initial value must not win over entry 0, so the first processed entry always loads unconditionally.
- **DONE:** outputs are held stable while out_valid && !out_ready, for an unbounded stall.
  - On an edge with out_ready=1: go to IDLE; out_valid drops; min_* keep their last value.
  - The next capture happens at the earliest on the following edge; there is no same-cycle output-to-input turnaround.
- **Ignored inputs:** in_valid is ignored outside IDLE, and out_ready is ignored outside DONE.
- **Throughput:** one window per N+2 cycles when out_ready is held at 1.

Test Plan:
1. LANES=1, hashResults[i]=200-i for i=0..48 (min 152 at i=48), kmers[i]=32'h1000+i:
   - min_hash=152, min_index=48, min_kmer=32'h1030;
   - out_valid rises exactly 49 edges after capture;
   - in_ready=0 throughout.
2. Ties:
   - all hashResults=254 except entries 5, 17 and 40 = 3 -> min_index=5, min_hash=3;
   - repeat with all entries equal 0 -> min_index=0.
3. Partial group, LANES=8 (N=7), minimum 0 at entry 48 only -> min_index=48; out_valid after 7 edges; phantom indices 49..55 never selected.
4. Output stall:
   - hold out_ready=0 for 20 cycles -> outputs constant, in_ready=0, and a new in_valid is not captured;
   - then out_ready=1 for one edge -> IDLE, and a second window is captured on the next edge.
5. Reset:
   - assert rstN for 1 cycle at scan edge 20 -> next cycle in_ready=1, out_valid=0, outputs 0;
   - a new window then completes correctly.
6. All entries 32'hFFFFFFFF -> min_hash=32'hFFFFFFFF, min_index=0, min_kmer=kmers[0]. Inputs are changed during SCAN to confirm the result comes from the captured copy.
